// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - decode/writeback bus of the multi-port register file
// Ports (grouped signals):
//   ra     NRD*ADDR_W  read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   pa     NRD*DATA_W  read data, port i = pa[i*DATA_W +: DATA_W]
//   rbusy  NRD         scoreboard busy bit of the register addressed by port i
//   we0/rw0/pw0        write port 0 (ALU writeback)
//   we1/rw1/pw1        write port 1 (memory writeback)
//   rsv/rsv_a          reserve request from issue
// Modports: master = pipeline side, slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD*DATA_W-1:0] pa;
  logic [NRD-1:0]        rbusy;
  logic                  we0;
  logic [ADDR_W-1:0]     rw0;
  logic [DATA_W-1:0]     pw0;
  logic                  we1;
  logic [ADDR_W-1:0]     rw1;
  logic [DATA_W-1:0]     pw1;
  logic                  rsv;
  logic [ADDR_W-1:0]     rsv_a;

  modport master (
    output ra, we0, rw0, pw0, we1, rw1, pw1, rsv, rsv_a,
    input  pa, rbusy
  );

  modport slave (
    input  ra, we0, rw0, pw0, we1, rw1, pw1, rsv, rsv_a,
    output pa, rbusy
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with busy scoreboard
// Ports:
//   clk    in     rising-edge clock for array and scoreboard updates
//   rst_n  in     asynchronous active-low reset; clears array and busy bits,
//                 forces all read data and busy outputs to 0 while low
//   bus    slave  regfile_mp_if: NRD combinational read ports, two write
//                 ports (port 1 has priority on collision), reserve port
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  // With a hardwired r0, writes and reserves to address 0 are dropped here,
  // so r0 is never written, never busy and never a bypass source.
  logic we0_eff, we1_eff, rsv_eff;
  assign we0_eff = bus.we0 && !((ZERO_R0 != 0) && (bus.rw0 == '0));
  assign we1_eff = bus.we1 && !((ZERO_R0 != 0) && (bus.rw1 == '0));
  assign rsv_eff = bus.rsv && !((ZERO_R0 != 0) && (bus.rsv_a == '0));

  // Reserve is applied after the clears so a new producer supersedes a
  // result arriving on the same edge.
  always_comb begin
    busy_nxt = busy;
    if (we0_eff) busy_nxt[bus.rw0] = 1'b0;
    if (we1_eff) busy_nxt[bus.rw1] = 1'b0;
    if (rsv_eff) busy_nxt[bus.rsv_a] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      busy <= '0;
    end else begin
      if (we0_eff) mem[bus.rw0] <= bus.pw0;
      // Port 1 is assigned last so it wins an address collision.
      if (we1_eff) mem[bus.rw1] <= bus.pw1;
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
    logic              hit0, hit1, hit_rsv;

    assign a       = bus.ra[i*ADDR_W +: ADDR_W];
    assign hit0    = we0_eff && (bus.rw0 == a);
    assign hit1    = we1_eff && (bus.rw1 == a);
    assign hit_rsv = rsv_eff && (bus.rsv_a == a);

    always_comb begin
      d = mem[a];
      b = busy[a];
      if (BYPASS != 0) begin
        if (hit1)      d = bus.pw1;
        else if (hit0) d = bus.pw0;
        // The result arriving now resolves the hazard, unless a new
        // reservation for the same register is issued this very cycle.
        if ((hit0 || hit1) && !hit_rsv) b = 1'b0;
      end
      if (!rst_n || ((ZERO_R0 != 0) && (a == '0))) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign bus.pa[i*DATA_W +: DATA_W] = d;
    assign bus.rbusy[i]               = b;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) ifa ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) ifb ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(3),  .NRD(4))  ifc ();

  // A: bypass + hardwired r0; B: no bypass, plain r0; C: small sweep config
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1), .ZERO_R0(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(0), .ZERO_R0(0))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4), .BYPASS(1), .ZERO_R0(0))
    u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  assign ifb.ra    = ifa.ra;
  assign ifb.we0   = ifa.we0;
  assign ifb.rw0   = ifa.rw0;
  assign ifb.pw0   = ifa.pw0;
  assign ifb.we1   = ifa.we1;
  assign ifb.rw1   = ifa.rw1;
  assign ifb.pw1   = ifa.pw1;
  assign ifb.rsv   = ifa.rsv;
  assign ifb.rsv_a = ifa.rsv_a;

  // Reference state: index 0 models A, index 1 models B.
  logic [DW-1:0] m_reg  [2][DEPTH];
  logic          m_busy [2][DEPTH];
  logic [15:0]   valc   [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic zr(input int k);
    return k == 0;
  endfunction

  function automatic logic eff_we0(input int k);
    return rst_n && ifa.we0 && !(zr(k) && ifa.rw0 == 0);
  endfunction

  function automatic logic eff_we1(input int k);
    return rst_n && ifa.we1 && !(zr(k) && ifa.rw1 == 0);
  endfunction

  function automatic logic eff_rsv(input int k);
    return rst_n && ifa.rsv && !(zr(k) && ifa.rsv_a == 0);
  endfunction

  function automatic logic [DW-1:0] exp_pa(input int k, input logic [AW-1:0] a);
    if (!rst_n || (zr(k) && a == 0)) return '0;
    if (k == 0 && eff_we1(k) && ifa.rw1 == a) return ifa.pw1;
    if (k == 0 && eff_we0(k) && ifa.rw0 == a) return ifa.pw0;
    return m_reg[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [AW-1:0] a);
    logic wr;
    if (!rst_n || (zr(k) && a == 0)) return 1'b0;
    wr = (eff_we0(k) && ifa.rw0 == a) || (eff_we1(k) && ifa.rw1 == a);
    if (k == 0 && wr && !(eff_rsv(k) && ifa.rsv_a == a)) return 1'b0;
    return m_busy[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < DEPTH; r++) begin
        m_reg[k][r]  = '0;
        m_busy[k][r] = 1'b0;
      end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (eff_we0(k)) begin m_reg[k][ifa.rw0] = ifa.pw0; m_busy[k][ifa.rw0] = 1'b0; end
      if (eff_we1(k)) begin m_reg[k][ifa.rw1] = ifa.pw1; m_busy[k][ifa.rw1] = 1'b0; end
      if (eff_rsv(k)) m_busy[k][ifa.rsv_a] = 1'b1;
    end
  endtask

  task automatic drive(input int w0, input int a0, input logic [31:0] d0,
                       input int w1, input int a1, input logic [31:0] d1,
                       input int rs, input int ar, input int r0, input int r1);
    ifa.we0 = w0[0]; ifa.rw0 = AW'(a0); ifa.pw0 = d0;
    ifa.we1 = w1[0]; ifa.rw1 = AW'(a1); ifa.pw1 = d1;
    ifa.rsv = rs[0]; ifa.rsv_a = AW'(ar);
    ifa.ra  = {AW'(r1), AW'(r0)};
  endtask

  task automatic check_ports();
    for (int p = 0; p < NR; p++) begin
      logic [AW-1:0] a;
      a = ifa.ra[p*AW +: AW];
      chk($sformatf("A.pa%0d@r%0d", p, a), ifa.pa[p*DW +: DW], exp_pa(0, a));
      chk($sformatf("A.rbusy%0d@r%0d", p, a), 32'(ifa.rbusy[p]), 32'(exp_busy(0, a)));
      chk($sformatf("B.pa%0d@r%0d", p, a), ifb.pa[p*DW +: DW], exp_pa(1, a));
      chk($sformatf("B.rbusy%0d@r%0d", p, a), 32'(ifb.rbusy[p]), 32'(exp_busy(1, a)));
    end
  endtask

  // Inputs change at negedge; settle samples 2 time units later.
  task automatic settle();
    #2;
    check_ports();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    ifc.ra = '0; ifc.we0 = 0; ifc.rw0 = '0; ifc.pw0 = '0;
    ifc.we1 = 0; ifc.rw1 = '0; ifc.pw1 = '0; ifc.rsv = 0; ifc.rsv_a = '0;
    // Reset with writes and bypass candidates present: everything reads 0.
    drive(1, 3, 32'hCAFEF00D, 1, 4, 32'h12345678, 1, 3, 3, 4);
    settle();
    chk("rst.A.pa0", ifa.pa[31:0], 32'h0);
    chk("rst.A.rbusy", 32'(ifa.rbusy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    rst_n = 1'b1;
    settle();
    advance();

    // Basic write, same-cycle bypass (A) vs old value (B), then read-back.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);
    settle();
    chk("basic.byp", ifa.pa[63:32], 32'hDEADBEEF);
    chk("basic.nobyp", ifb.pa[31:0], 32'h0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    settle();
    chk("basic.rd", ifb.pa[63:32], 32'hDEADBEEF);
    advance();

    // Write collision: port 1 wins in bypass and array.
    drive(1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0, 7, 7);
    settle();
    chk("coll.byp", ifa.pa[31:0], 32'h22222222);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    settle();
    chk("coll.rd", ifb.pa[31:0], 32'h22222222);
    advance();

    // Hardwired r0 on A; B stores and reserves r0 normally.
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
    settle();
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("zero.pa", ifa.pa[31:0], 32'h0);
    chk("zero.rbusy", 32'(ifa.rbusy[0]), 32'h0);
    chk("zero.B.pa", ifb.pa[31:0], 32'hFFFFFFFF);
    advance();

    // Scoreboard: reserve, clearing write, reserve+write same edge.
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
    settle();
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    settle();
    chk("sb.busy", 32'(ifa.rbusy[0]), 32'h1);
    advance();
    drive(0, 0, 0, 1, 9, 32'h000000A5, 0, 0, 9, 9);
    settle();
    chk("sb.clr.byp", 32'(ifa.rbusy[1]), 32'h0);
    chk("sb.clr.nobyp", 32'(ifb.rbusy[1]), 32'h1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    settle();
    chk("sb.cleared", 32'(ifb.rbusy[0]), 32'h0);
    chk("sb.data", ifb.pa[31:0], 32'h000000A5);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
    settle();
    advance();
    drive(1, 9, 32'h5A5A5A5A, 0, 0, 0, 1, 9, 9, 9);
    settle();
    chk("sb.rsvwr.byp", 32'(ifa.rbusy[0]), 32'h1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    settle();
    chk("sb.rsvwr.next", 32'(ifa.rbusy[0]), 32'h1);
    advance();

    // Random traffic, addresses biased to a small window for collisions.
    for (int n = 0; n < 400; n++) begin
      int lim;
      lim = ($urandom_range(0, 1) == 1) ? 7 : 31;
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, lim)), $urandom,
            int'($urandom_range(0, 1)), int'($urandom_range(0, lim)), $urandom,
            int'($urandom_range(0, 2) == 0), int'($urandom_range(0, lim)),
            int'($urandom_range(0, lim)), int'($urandom_range(0, lim)));
      settle();
      advance();
    end

    // Reset asserted mid-cycle with a write pending: write discarded.
    drive(1, 3, 32'h0BADF00D, 1, 12, 32'h87654321, 1, 12, 3, 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.A.pa", ifa.pa, '0);
    chk("midrst.B.pa", ifb.pa[31:0], 32'h0);
    chk("midrst.B.rbusy", 32'(ifb.rbusy), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 12);
    rst_n = 1'b1;
    for (int r = 1; r < DEPTH; r++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, r, DEPTH - r);
      settle();
      chk($sformatf("postrst.r%0d", r), ifb.pa[31:0], 32'h0);
      advance();
    end

    // Small configuration: write all 8 regs distinct, read via 4 ports.
    for (int k = 0; k < 8; k++) valc[k] = {13'($urandom), 3'(k)};
    for (int k = 0; k < 4; k++) begin
      ifc.we0 = 1; ifc.rw0 = 3'(2*k);     ifc.pw0 = valc[2*k];
      ifc.we1 = 1; ifc.rw1 = 3'(2*k + 1); ifc.pw1 = valc[2*k + 1];
      @(posedge clk);
      @(negedge clk);
    end
    ifc.we0 = 0; ifc.we1 = 0;
    for (int rot = 0; rot < 8; rot++) begin
      for (int p = 0; p < 4; p++) ifc.ra[p*3 +: 3] = 3'((rot + p) % 8);
      #2;
      for (int p = 0; p < 4; p++)
        chk($sformatf("C.pa%0d@r%0d", p, (rot + p) % 8),
            32'(ifc.pa[p*16 +: 16]), 32'(valc[(rot + p) % 8]));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
